// File: rtl/gpio_ctrl_pkg.sv
// Shared definitions for the GPIO controller: register indices and the CFG word layout.
package gpio_ctrl_pkg;

    typedef enum logic [2:0] {
        REG_DIN      = 3'd0,
        REG_DOUT     = 3'd1,
        REG_DOUT_SET = 3'd2,
        REG_DOUT_CLR = 3'd3,
        REG_RISE_EN  = 3'd4,
        REG_FALL_EN  = 3'd5,
        REG_STATUS   = 3'd6,
        REG_CFG      = 3'd7
    } gpio_reg_e;

    localparam int unsigned CFG_N_IN_LSB  = 0;
    localparam int unsigned CFG_N_OUT_LSB = 8;
    localparam int unsigned CFG_DEB_LSB   = 16;

    function automatic logic [31:0] cfg_word(input int unsigned n_in,
                                             input int unsigned n_out,
                                             input int unsigned deb);
        logic [31:0] w;
        w = 32'd0;
        w[CFG_N_IN_LSB  +: 8] = 8'(n_in);
        w[CFG_N_OUT_LSB +: 8] = 8'(n_out);
        w[CFG_DEB_LSB   +: 8] = 8'(deb);
        return w;
    endfunction

endpackage

// File: rtl/gpio_ctrl_debounce.sv
// One input channel: 2-flop synchronizer followed by a stable-value debouncer.
// rise_o/fall_o flag the edge on which the stable value S is about to change.
module gpio_debounce #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic s_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic s_q;
    logic s_d;

    // Synchronizer and stable-value registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            s_q     <= 1'b0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            s_q     <= s_d;
        end
    end

    generate
        if (DEB_CYCLES == 0) begin : g_bypass
            // Loading what sync2 is about to take keeps S identical to the synchronizer output.
            assign s_d = sync1_q;
        end else begin : g_filter
            localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            // Count consecutive cycles the synchronized input disagrees with S.
            always_comb begin
                cnt_d = cnt_q;
                s_d   = s_q;
                if (sync2_q == s_q) begin
                    cnt_d = {CW{1'b0}};
                end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                    s_d   = sync2_q;
                    cnt_d = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            // Debounce counter register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= {CW{1'b0}};
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    assign s_o    = s_q;
    assign rise_o = s_d & ~s_q;
    assign fall_o = ~s_d & s_q;

endmodule

// File: rtl/gpio_ctrl.sv
// GPIO controller on a simple localbus: debounced inputs with edge interrupts,
// set/clear-able outputs, one-cycle registered reads.
module gpio_ctrl
    import gpio_ctrl_pkg::*;
#(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     N_IN       = 13,
    parameter int unsigned     N_OUT      = 8,
    parameter int unsigned     DEB_CYCLES = 16,
    parameter logic [XLEN-1:0] BASE_ADDR  = 32'h8000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  addr,
    input  logic [XLEN-1:0]  qin,
    input  logic [2:0]       we,
    output logic [XLEN-1:0]  qout,
    input  logic [N_IN-1:0]  gpio_pin_in,
    output logic [N_OUT-1:0] gpio_pin_out,
    output logic             irq
);

    logic [N_IN-1:0]  din_s;
    logic [N_IN-1:0]  rise_ev_s;
    logic [N_IN-1:0]  fall_ev_s;
    logic [N_IN-1:0]  set_ev_s;
    logic             sel_s;
    logic             wr_s;
    gpio_reg_e        idx_s;
    logic [XLEN-1:0]  rdata_s;
    logic             unused_s;

    logic [N_OUT-1:0] dout_q,    dout_d;
    logic [N_IN-1:0]  rise_en_q, rise_en_d;
    logic [N_IN-1:0]  fall_en_q, fall_en_d;
    logic [N_IN-1:0]  status_q,  status_d;
    logic [XLEN-1:0]  qout_q,    qout_d;
    logic             irq_q,     irq_d;

    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_in
            gpio_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
                .clk    (clk),
                .rst    (rst),
                .pin_i  (gpio_pin_in[gi]),
                .s_o    (din_s[gi]),
                .rise_o (rise_ev_s[gi]),
                .fall_o (fall_ev_s[gi])
            );
        end
    endgenerate

    assign sel_s    = (addr[XLEN-1:5] == BASE_ADDR[XLEN-1:5]);
    assign wr_s     = sel_s && (we != 3'd0);
    assign idx_s    = gpio_reg_e'(addr[4:2]);
    assign set_ev_s = (rise_ev_s & rise_en_q) | (fall_ev_s & fall_en_q);
    assign unused_s = ^{addr[1:0], qin};

    // Read mux; write-only registers read back as zero.
    always_comb begin
        rdata_s = {XLEN{1'b0}};
        case (idx_s)
            REG_DIN:     rdata_s = XLEN'(din_s);
            REG_DOUT:    rdata_s = XLEN'(dout_q);
            REG_RISE_EN: rdata_s = XLEN'(rise_en_q);
            REG_FALL_EN: rdata_s = XLEN'(fall_en_q);
            REG_STATUS:  rdata_s = XLEN'(status_q);
            REG_CFG:     rdata_s = XLEN'(cfg_word(N_IN, N_OUT, DEB_CYCLES));
            default:     rdata_s = {XLEN{1'b0}};
        endcase
    end

    // Register next-state; a STATUS set event outranks a simultaneous W1C.
    always_comb begin
        dout_d    = dout_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        status_d  = status_q | set_ev_s;
        if (wr_s) begin
            case (idx_s)
                REG_DOUT:     dout_d    = qin[N_OUT-1:0];
                REG_DOUT_SET: dout_d    = dout_q | qin[N_OUT-1:0];
                REG_DOUT_CLR: dout_d    = dout_q & ~qin[N_OUT-1:0];
                REG_RISE_EN:  rise_en_d = qin[N_IN-1:0];
                REG_FALL_EN:  fall_en_d = qin[N_IN-1:0];
                REG_STATUS:   status_d  = (status_q & ~qin[N_IN-1:0]) | set_ev_s;
                default:      dout_d    = dout_q;
            endcase
        end else begin
            dout_d = dout_q;
        end
    end

    // Output-side next-state: read data and interrupt level.
    always_comb begin
        qout_d = sel_s ? rdata_s : {XLEN{1'b0}};
        irq_d  = |status_q;
    end

    // All architectural registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q    <= {N_OUT{1'b0}};
            rise_en_q <= {N_IN{1'b0}};
            fall_en_q <= {N_IN{1'b0}};
            status_q  <= {N_IN{1'b0}};
            qout_q    <= {XLEN{1'b0}};
            irq_q     <= 1'b0;
        end else begin
            dout_q    <= dout_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            qout_q    <= qout_d;
            irq_q     <= irq_d;
        end
    end

    assign qout         = qout_q;
    assign gpio_pin_out = dout_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the register/debounce rules.
module tb_gpio_ctrl;

    localparam int          NI   = 13;
    localparam int          NO   = 8;
    localparam int          DEB  = 16;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   addr;
    logic [31:0]   qin;
    logic [2:0]    we;
    logic [31:0]   qout;
    logic [NI-1:0] pins;
    logic [NO-1:0] gpio_pin_out;
    logic          irq;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    logic [NI-1:0] m_s, m_pd1, m_pd2, m_rise, m_fall, m_status;
    logic [NO-1:0] m_dout;
    logic          m_irq;
    logic [31:0]   m_qout;
    int            m_run [NI];

    gpio_ctrl #(
        .XLEN(32), .N_IN(NI), .N_OUT(NO), .DEB_CYCLES(DEB), .BASE_ADDR(BASE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .qin          (qin),
        .we           (we),
        .qout         (qout),
        .gpio_pin_in  (pins),
        .gpio_pin_out (gpio_pin_out),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] a(input int idx);
        return BASE | (32'(idx) << 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s = '0; m_pd1 = '0; m_pd2 = '0; m_rise = '0; m_fall = '0; m_status = '0;
        m_dout = '0; m_irq = 1'b0; m_qout = '0;
        for (int i = 0; i < NI; i++) m_run[i] = 0;
    endtask

    // Advance the model across one clock edge using the current bus/pin inputs.
    task automatic model_edge();
        logic          sel;
        logic [31:0]   rd;
        logic [NI-1:0] new_s, set_ev, new_status;
        logic [NO-1:0] new_dout;
        sel = (addr[31:5] == BASE[31:5]);
        case (addr[4:2])
            3'd0:    rd = 32'(m_s);
            3'd1:    rd = 32'(m_dout);
            3'd4:    rd = 32'(m_rise);
            3'd5:    rd = 32'(m_fall);
            3'd6:    rd = 32'(m_status);
            3'd7:    rd = 32'h0010_080D;
            default: rd = 32'd0;
        endcase
        // The synchronized value is the pin as sampled two edges earlier; S flips
        // once it has disagreed with S for DEB consecutive edges.
        new_s = m_s;
        for (int i = 0; i < NI; i++) begin
            if (m_pd2[i] == m_s[i]) begin
                m_run[i] = 0;
            end else begin
                m_run[i]++;
                if (m_run[i] >= DEB) begin
                    new_s[i] = m_pd2[i];
                    m_run[i] = 0;
                end
            end
        end
        set_ev     = (new_s & ~m_s & m_rise) | (~new_s & m_s & m_fall);
        new_status = m_status | set_ev;
        new_dout   = m_dout;
        if (sel && we != 3'd0) begin
            case (addr[4:2])
                3'd1: new_dout = qin[NO-1:0];
                3'd2: new_dout = m_dout | qin[NO-1:0];
                3'd3: new_dout = m_dout & ~qin[NO-1:0];
                3'd4: m_rise = qin[NI-1:0];
                3'd5: m_fall = qin[NI-1:0];
                3'd6: new_status = (m_status & ~qin[NI-1:0]) | set_ev;
                default: ;
            endcase
        end
        m_irq    = |m_status;
        m_qout   = sel ? rd : 32'd0;
        m_status = new_status;
        m_dout   = new_dout;
        m_s      = new_s;
        m_pd2    = m_pd1;
        m_pd1    = pins;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("qout", qout, m_qout);
        chk("gpio_pin_out", 32'(gpio_pin_out), 32'(m_dout));
        chk("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic wr(input int idx, input logic [31:0] data);
        addr = a(idx); qin = data; we = 3'b100;
        step();
        we = 3'd0; qin = 32'd0;
    endtask

    task automatic rd(input int idx);
        addr = a(idx); we = 3'd0;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_qout", qout, 32'd0);
        chk("rst_pin_out", 32'(gpio_pin_out), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic done;
        rst = 1'b1; addr = 32'd0; qin = 32'd0; we = 3'd0; pins = '0;
        model_reset();
        do_reset();

        rd(7);
        chk("cfg", qout, 32'h0010_080D);
        addr = 32'h1234_0004; step();
        chk("unmapped", qout, 32'd0);
        addr = BASE + 32'h20; step();
        chk("above_block", qout, 32'd0);

        wr(1, 32'h0000_00A5);
        chk("dout_a5", 32'(gpio_pin_out), 32'h0000_00A5);
        wr(2, 32'h0000_000A);
        chk("dout_set", 32'(gpio_pin_out), 32'h0000_00AF);
        wr(3, 32'h0000_0081);
        chk("dout_clr", 32'(gpio_pin_out), 32'h0000_002E);
        rd(1);
        chk("dout_read", qout, 32'h0000_002E);
        rd(2);
        chk("set_reads_0", qout, 32'd0);

        // Clean step on pin 3: S changes 18 edges later, seen on qout one edge after.
        addr = a(0); pins[3] = 1'b1;
        for (int i = 1; i <= 19; i++) begin
            step();
            if (i == 18) chk("din3_early", 32'(qout[3]), 32'd0);
            if (i == 19) chk("din3_settled", 32'(qout[3]), 32'd1);
        end

        // 10-cycle glitch on pin 4 must be filtered out.
        pins[4] = 1'b1;
        for (int i = 0; i < 10; i++) step();
        pins[4] = 1'b0;
        for (int i = 0; i < 25; i++) step();
        chk("glitch_blocked", 32'(qout[4]), 32'd0);
        pins[3] = 1'b0;
        for (int i = 0; i < 20; i++) step();

        // Rising interrupt on pin 0, then W1C.
        wr(4, 32'h1);
        pins[0] = 1'b1; addr = a(6);
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            done = irq;
        end
        chk("irq_raised", 32'(irq), 32'd1);
        chk("status_set", qout, 32'h1);
        wr(6, 32'h1);
        rd(6);
        chk("irq_cleared", 32'(irq), 32'd0);
        chk("status_cleared", qout, 32'd0);

        // Falling event sets STATUS[0]; then a W1C coincides with a new rise.
        pins[0] = 1'b0;
        wr(5, 32'h1);
        for (int i = 0; i < 20; i++) rd(6);
        chk("fall_status", qout, 32'h1);
        pins[0] = 1'b1; addr = a(0);
        for (int i = 1; i <= 17; i++) step();
        wr(6, 32'h1);
        rd(6);
        chk("set_beats_w1c", qout, 32'h1);
        chk("irq_held", 32'(irq), 32'd1);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < NI; b++)
                if ($urandom_range(23) == 0) pins[b] = ~pins[b];
            if ($urandom_range(9) < 8) addr = a($urandom_range(7)) | 32'($urandom_range(3));
            else addr = $urandom;
            we  = ($urandom_range(2) == 0) ? 3'($urandom_range(7, 1)) : 3'd0;
            qin = $urandom;
            step();
        end
        we = 3'd0; qin = 32'd0;

        // Reset in the middle of a debounce count.
        pins = '1; addr = a(0);
        for (int i = 0; i < 8; i++) step();
        do_reset();
        for (int i = 1; i <= 19; i++) begin
            step();
            if (i == 18) chk("post_rst_early", qout, 32'd0);
        end
        chk("post_rst_din", qout, 32'h0000_1FFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
